// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM encodings, reset PC default
// and the opcode constants the control unit also decodes.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;

  // Instruction fetches are word-sized, so the two low address bits are
  // always forced to zero regardless of what arithmetic produced them.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  function automatic logic is_jump_op(input logic [5:0] opcode);
    return opcode == OP_J;
  endfunction

  function automatic logic is_beq_op(input logic [5:0] opcode);
    return opcode == OP_BEQ;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: single request/ack handshake with data
// returned in the ack cycle.
interface fetch_unit_if;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck;
  logic [31:0] IMemRdata;

  modport master (
    output IMemReq,
    output IMemAddr,
    input  IMemAck,
    input  IMemRdata
  );

  modport slave (
    input  IMemReq,
    input  IMemAddr,
    output IMemAck,
    output IMemRdata
  );
endinterface

// File: rtl/fetch_unit_pc_next.sv
// Purely combinational next-PC selection: jump, taken branch or fall-through.
module pc_next (
  input  logic [31:0] pc_i,
  input  logic [25:0] jump_index_i,
  input  logic        jump_i,
  input  logic        pcsrc_i,
  input  logic [31:0] sign_imm_i,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] pc_next_o
);

  logic [31:0] branch_target;
  logic [31:0] jump_target;

  assign pc_plus4_o    = pc_i + 32'd4;
  // Offset is in words; the shift drops its top two bits and the sum wraps.
  assign branch_target = pc_plus4_o + (sign_imm_i << 2);
  assign jump_target   = {pc_plus4_o[31:28], jump_index_i, 2'b00};

  // Jump wins over a taken branch when both are flagged.
  always_comb begin
    pc_next_o = pc_plus4_o;
    if (jump_i) begin
      pc_next_o = jump_target;
    end else if (pcsrc_i) begin
      pc_next_o = branch_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: requests one instruction word at PC, holds it for decode
// until it is consumed, then advances PC by fall-through, branch or jump.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         CLK,
  input  logic         RST,
  fetch_unit_if.master imem,
  input  logic         Stall,
  input  logic         Jump,
  input  logic         PCSrc,
  input  logic [31:0]  SignImm,
  output logic [31:0]  Instr,
  output logic         InstrValid,
  output logic [31:0]  PC,
  output logic [31:0]  PCPlus4
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4;
  logic [31:0] pc_target;

  pc_next u_pc_next (
    .pc_i         (pc_q),
    .jump_index_i (instr_q[25:0]),
    .jump_i       (Jump),
    .pcsrc_i      (PCSrc),
    .sign_imm_i   (SignImm),
    .pc_plus4_o   (pc_plus4),
    .pc_next_o    (pc_target)
  );

  // The request address is the PC itself, so it is stable for the whole
  // REQ phase no matter how long the ack takes.
  assign imem.IMemAddr = pc_q;

  assign Instr      = instr_q;
  assign InstrValid = valid_q;
  assign PC         = pc_q;
  assign PCPlus4    = pc_plus4;

  // Next-state and request decode; ack is only honoured while in REQ.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    valid_d      = valid_q;
    imem.IMemReq = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        imem.IMemReq = 1'b1;
        if (imem.IMemAck) begin
          instr_d = imem.IMemRdata;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!Stall) begin
          pc_d    = word_align(pc_target);
          valid_d = 1'b0;
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any outstanding request.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      pc_q    <= word_align(RESET_PC);
      instr_q <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of next-PC vectors chained from
// reset, plus hand-written handshake, stall and reset sequences.
module tb_fetch_unit;

  typedef struct {
    logic [31:0] instr;
    logic        jump;
    logic        pcsrc;
    logic [31:0] sign_imm;
    logic [31:0] exp_next;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Stall;
  logic        Jump;
  logic        PCSrc;
  logic [31:0] SignImm;
  logic [31:0] Instr;
  logic        InstrValid;
  logic [31:0] PC;
  logic [31:0] PCPlus4;

  int tests_run    = 0;
  int tests_failed = 0;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .imem       (bus),
    .Stall      (Stall),
    .Jump       (Jump),
    .PCSrc      (PCSrc),
    .SignImm    (SignImm),
    .Instr      (Instr),
    .InstrValid (InstrValid),
    .PC         (PC),
    .PCPlus4    (PCPlus4)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  vec_t        vecs [12];
  logic [31:0] cur_pc;
  logic [31:0] held_pc;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004};
    vecs[1]  = '{32'h2001_0001, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0008};
    vecs[2]  = '{32'h1000_0001, 1'b0, 1'b1, 32'h0000_0001, 32'h0000_0010};
    vecs[3]  = '{32'h1000_FFFE, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0000_000C};
    vecs[4]  = '{32'h1000_FFFC, 1'b0, 1'b1, 32'h0BFF_FFFC, 32'h3000_0000};
    vecs[5]  = '{32'h0800_0040, 1'b1, 1'b1, 32'h0000_0005, 32'h3000_0100};
    vecs[6]  = '{32'h0BFF_FFFF, 1'b1, 1'b0, 32'h0000_0000, 32'h3FFF_FFFC};
    vecs[7]  = '{32'h0000_0020, 1'b0, 1'b0, 32'h0000_0000, 32'h4000_0000};
    vecs[8]  = '{32'h1000_FFFF, 1'b0, 1'b1, 32'h2FFF_FFFF, 32'h0000_0000};
    vecs[9]  = '{32'h0800_0003, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_000C};
    vecs[10] = '{32'h1000_FFFB, 1'b0, 1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFC};
    vecs[11] = '{32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000};

    RST           = 1'b1;
    Stall         = 1'b0;
    Jump          = 1'b0;
    PCSrc         = 1'b0;
    SignImm       = 32'h0;
    bus.IMemAck   = 1'b0;
    bus.IMemRdata = 32'h0;

    // Reset state
    do_reset();
    $display("[TB] reset state");
    check("rst_pc", PC, 32'h0000_0000);
    check("rst_instr", Instr, 32'h0000_0000);
    check("rst_valid", {31'b0, InstrValid}, 32'h0);
    check("rst_req", {31'b0, bus.IMemReq}, 32'h0);
    check("rst_pcplus4", PCPlus4, 32'h0000_0004);

    // Back-to-back fetch with immediate ack: REQ every second cycle
    bus.IMemAck   = 1'b1;
    bus.IMemRdata = 32'h0000_0000;
    for (int k = 0; k < 3; k++) begin
      step();
      $display("[TB] stream fetch %0d addr=%h req=%b", k, bus.IMemAddr, bus.IMemReq);
      check("stream_req_hi", {31'b0, bus.IMemReq}, 32'h1);
      check("stream_addr", bus.IMemAddr, 32'(k * 4));
      step();
      check("stream_req_lo", {31'b0, bus.IMemReq}, 32'h0);
      check("stream_valid", {31'b0, InstrValid}, 32'h1);
    end
    bus.IMemAck = 1'b0;

    // Table of next-PC vectors chained from reset
    do_reset();
    step();
    cur_pc = 32'h0000_0000;
    for (int i = 0; i < 12; i++) begin
      check("vec_req", {31'b0, bus.IMemReq}, 32'h1);
      check("vec_addr", bus.IMemAddr, cur_pc);
      bus.IMemAck   = 1'b1;
      bus.IMemRdata = vecs[i].instr;
      Stall         = 1'b0;
      Jump          = vecs[i].jump;
      PCSrc         = vecs[i].pcsrc;
      SignImm       = vecs[i].sign_imm;
      step();
      bus.IMemAck = 1'b0;
      check("vec_valid", {31'b0, InstrValid}, 32'h1);
      check("vec_instr", Instr, vecs[i].instr);
      check("vec_pc", PC, cur_pc);
      check("vec_pcplus4", PCPlus4, cur_pc + 32'd4);
      check("vec_hold_req", {31'b0, bus.IMemReq}, 32'h0);
      step();
      $display("[TB] vec %0d pc=%h instr=%h j=%b b=%b imm=%h -> addr=%h", i, cur_pc,
               vecs[i].instr, vecs[i].jump, vecs[i].pcsrc, vecs[i].sign_imm, bus.IMemAddr);
      check("vec_next_addr", bus.IMemAddr, vecs[i].exp_next);
      check("vec_valid_clr", {31'b0, InstrValid}, 32'h0);
      cur_pc = vecs[i].exp_next;
    end
    Jump    = 1'b0;
    PCSrc   = 1'b0;
    SignImm = 32'h0;

    // Ack delayed three cycles: request held stable for four cycles
    bus.IMemRdata = 32'h1234_5678;
    for (int k = 0; k < 4; k++) begin
      $display("[TB] delayed ack wait %0d req=%b addr=%h", k, bus.IMemReq, bus.IMemAddr);
      check("dly_req", {31'b0, bus.IMemReq}, 32'h1);
      check("dly_addr", bus.IMemAddr, cur_pc);
      check("dly_valid", {31'b0, InstrValid}, 32'h0);
      if (k == 3) bus.IMemAck = 1'b1;
      step();
    end
    check("dly_load_valid", {31'b0, InstrValid}, 32'h1);
    check("dly_load_instr", Instr, 32'h1234_5678);

    // Stall for five cycles in HOLD while a stray ack carries other data
    Stall         = 1'b1;
    bus.IMemAck   = 1'b1;
    bus.IMemRdata = 32'hFFFF_0000;
    held_pc       = PC;
    for (int k = 0; k < 5; k++) begin
      step();
      $display("[TB] stall cycle %0d pc=%h instr=%h valid=%b req=%b", k, PC, Instr, InstrValid,
               bus.IMemReq);
      check("stall_pc", PC, held_pc);
      check("stall_instr", Instr, 32'h1234_5678);
      check("stall_valid", {31'b0, InstrValid}, 32'h1);
      check("stall_req", {31'b0, bus.IMemReq}, 32'h0);
    end

    // Reset in HOLD overrides a consume with Jump set
    RST   = 1'b1;
    Stall = 1'b0;
    Jump  = 1'b1;
    step();
    $display("[TB] reset in hold pc=%h valid=%b", PC, InstrValid);
    check("rsthold_pc", PC, 32'h0000_0000);
    check("rsthold_valid", {31'b0, InstrValid}, 32'h0);
    check("rsthold_instr", Instr, 32'h0000_0000);
    check("rsthold_req", {31'b0, bus.IMemReq}, 32'h0);
    RST         = 1'b0;
    Jump        = 1'b0;
    bus.IMemAck = 1'b0;
    step();
    step();
    step();

    // Reset mid-REQ, then a late ack in IDLE must be ignored
    check("midreq_pre_req", {31'b0, bus.IMemReq}, 32'h1);
    RST = 1'b1;
    step();
    RST           = 1'b0;
    bus.IMemAck   = 1'b1;
    bus.IMemRdata = 32'hDEAD_BEEF;
    step();
    $display("[TB] late ack after reset valid=%b instr=%h addr=%h", InstrValid, Instr, bus.IMemAddr);
    check("late_valid", {31'b0, InstrValid}, 32'h0);
    check("late_instr", Instr, 32'h0000_0000);
    check("late_req", {31'b0, bus.IMemReq}, 32'h1);
    check("late_addr", bus.IMemAddr, 32'h0000_0000);
    bus.IMemAck = 1'b0;
    step();
    check("late_still_invalid", {31'b0, InstrValid}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC value loaded on reset.
REQ-002 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 RST  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 IMemReq  output  1  SHALL be the instruction-memory read request.
REQ-005 IMemAddr  output  32  SHALL be the byte address of the requested word.
REQ-006 IMemAck  input  1  SHALL be the memory completion strobe; data is valid in the same cycle.
REQ-007 IMemRdata  input  32  SHALL be the instruction word returned by memory.
REQ-008 Stall  input  1  SHALL be the downstream hold; high blocks consumption of Instr.
REQ-009 Jump  input  1  SHALL be the decoded jump indication for the current Instr.
REQ-010 PCSrc  input  1  SHALL be the decoded taken-branch indication (Branch&Zero) for the current Instr.
REQ-011 SignImm  input  32  SHALL be the sign-extended 16-bit branch offset of the current Instr, in words.
REQ-012 Instr  output  32  SHALL be the held instruction; Opcode=Instr[31:26] and Funct=Instr[5:0] drive decode.
REQ-013 InstrValid  output  1  SHALL mark Instr as valid for decode.
REQ-014 PC  output  32  SHALL be the address of the instruction in Instr.
REQ-015 PCPlus4  output  32  SHALL be PC+4, modulo 2^32.

Function
REQ-016 The FSM SHALL have states IDLE, REQ, HOLD, binary encoded.
REQ-017 IDLE SHALL last exactly one cycle, then go to REQ.
REQ-018 In REQ, IMemReq SHALL be 1 and IMemAddr SHALL equal PC, both stable until the ack cycle.
REQ-019 In REQ with IMemAck=1, Instr SHALL load IMemRdata, InstrValid SHALL go to 1 next cycle, and the state SHALL go to HOLD.
REQ-020 In REQ with IMemAck=0, the FSM SHALL stay in REQ indefinitely, with no timeout.
REQ-021 IMemAck SHALL be ignored in IDLE and HOLD.
REQ-022 In HOLD with Stall=1, PC, Instr and InstrValid SHALL be held.
REQ-023 In HOLD with Stall=0 (consume cycle), Jump, PCSrc and SignImm SHALL be sampled, PC SHALL load next-PC, InstrValid SHALL clear, and the state SHALL go to REQ.
REQ-024 Next-PC with Jump=1 SHALL be {PCPlus4[31:28], Instr[25:0], 2'b00}; Jump SHALL take priority over PCSrc.
REQ-025 Next-PC with PCSrc=1 and Jump=0 SHALL be PCPlus4 + (SignImm<<2), truncated to 32 bits.
REQ-026 Next-PC otherwise SHALL be PCPlus4.
REQ-027 PC[1:0] SHALL always read 2'b00; all address arithmetic SHALL wrap modulo 2^32 without error.
REQ-028 IMemReq SHALL be 0 whenever the state is not REQ.
REQ-029 Throughput SHALL be one instruction per (ack latency + 2) cycles minimum: 1 REQ cycle + 1 HOLD cycle when ack arrives in the first REQ cycle.

Reset
REQ-030 With RST=1 at a clock edge: PC=RESET_PC, Instr=32'h0000_0000, InstrValid=0, state=IDLE, IMemReq=0 from the next cycle.
REQ-031 Reset during REQ SHALL abandon the outstanding request; a late IMemAck SHALL be ignored by REQ-021.
REQ-032 RST SHALL override Stall, Jump, PCSrc and IMemAck in the same cycle.

Structure
REQ-033 A shared package SHALL hold the FSM state encodings, the RESET_PC default, and opcode constants J=6'b000010 and BEQ=6'b000100, shared with the control unit.
REQ-034 The next-PC adder and mux SHALL be one combinational sub-module, pc_next; all state SHALL live in fetch_unit.

Verification
REQ-035 Test: reset, IMemAck=1 in the first REQ cycle, Stall=0 -> IMemAddr sequence 0x0, 0x4, 0x8, with IMemReq high every second cycle.
REQ-036 Test: ack delayed 3 cycles -> IMemReq and IMemAddr stay stable for 4 cycles, then exactly one Instr load.
REQ-037 Test: PC=0x0000_0010, PCSrc=1, SignImm=0xFFFF_FFFE -> next IMemAddr=0x0000_000C.
REQ-038 Test: PC=0x3000_0000, Instr=0x0800_0040, Jump=1, PCSrc=1 -> next IMemAddr=0x3000_0100.
REQ-039 Test: Stall held 5 cycles in HOLD -> PC, Instr and InstrValid unchanged, and no IMemReq asserted.
REQ-040 Test: RST pulsed mid-REQ, then IMemAck=1 the next cycle -> ack ignored, InstrValid=0, next IMemAddr=RESET_PC.
